// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory arbiter.
// Holds the lock-state encoding, the common request view used to route the
// winning requester onto the memory port, and the word-alignment helper.
package imem_pkg;

    // Size of the byte-addressed, big-endian instruction memory
    localparam int IMEM_BYTES = 1024;

    // Width of the loader starvation counter (MAX_WAIT is limited to 1..15)
    localparam int WAIT_CNT_W = 4;

    // Port ownership states
    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        LOCK_PEND = 2'd1,
        LOCKED    = 2'd2
    } arb_state_t;

    // Requester-neutral view of one word access
    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } imem_req_t;

    // A word access is misaligned when either of the two byte-offset bits is set
    function automatic logic addr_misaligned(input logic [1:0] lsb);
        addr_misaligned = (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/imem_starve_cnt.sv
// imem_starve_cnt: saturating count of cycles the loader has been kept waiting.
// Clears on any loader grant; at_max tells the arbiter to hand the port to the
// loader regardless of fetch traffic.
module imem_starve_cnt
    import imem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [WAIT_CNT_W-1:0] MAX_C = MAX_WAIT[WAIT_CNT_W-1:0];
    localparam logic [WAIT_CNT_W-1:0] ONE_C = WAIT_CNT_W'(1);

    logic [WAIT_CNT_W-1:0] cnt_r;

    // Count blocked loader cycles, saturating at MAX_WAIT; a grant takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_max = (cnt_r == MAX_C);

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single instruction-memory port between the IF-stage
// fetch requester and the program-loader/debug requester, one word per cycle.
// Fetch has priority, bounded by a starvation counter; the loader can take
// exclusive ownership with l_lock (NORMAL -> LOCK_PEND -> LOCKED).
// Optional build macro: IMEM_ARB_ALIGN_CHECK_EN -- when defined, misaligned
// granted accesses are suppressed and answered with err = 1, rdata = 0.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int MAX_WAIT  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // fetch requester
    input  logic                 f_valid,
    input  logic [31:0]          f_addr,
    output logic                 f_ready,
    output logic                 f_rvalid,
    output logic [31:0]          f_rdata,
    // loader requester
    input  logic                 l_valid,
    input  logic                 l_we,
    input  logic [31:0]          l_addr,
    input  logic [31:0]          l_wdata,
    input  logic                 l_lock,
    output logic                 l_ready,
    output logic                 l_rvalid,
    output logic [31:0]          l_rdata,
    output logic                 locked,
    // memory port
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_we,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    output logic                 err
);

    arb_state_t  state_r;
    logic        locked_r;

    imem_req_t   f_req_s;
    imem_req_t   l_req_s;
    imem_req_t   gnt_req_s;

    logic        f_gnt_s;
    logic        l_gnt_s;
    logic        at_max_s;
    logic        wait_inc_s;
    logic        bad_align_s;

    logic        f_rvalid_r;
    logic        l_rvalid_r;
    logic        err_r;
    logic [31:0] f_rdata_r;
    logic [31:0] l_rdata_r;

    // Pack each requester's fields into the common request view
    always_comb begin
        f_req_s       = '0;
        f_req_s.valid = f_valid;
        f_req_s.we    = 1'b0;
        f_req_s.addr  = f_addr;
        f_req_s.wdata = 32'h0000_0000;

        l_req_s       = '0;
        l_req_s.valid = l_valid;
        l_req_s.we    = l_we;
        l_req_s.addr  = l_addr;
        l_req_s.wdata = l_wdata;
    end

    // Choose at most one winner per cycle; nothing is granted while in reset
    always_comb begin
        f_gnt_s = 1'b0;
        l_gnt_s = 1'b0;
        if (!rst_n) begin
            f_gnt_s = 1'b0;
            l_gnt_s = 1'b0;
        end else begin
            case (state_r)
                NORMAL: begin
                    // Fetch wins unless the loader has waited long enough
                    if (l_valid && (at_max_s || !f_valid)) begin
                        l_gnt_s = 1'b1;
                    end else if (f_valid) begin
                        f_gnt_s = 1'b1;
                    end else begin
                        f_gnt_s = 1'b0;
                        l_gnt_s = 1'b0;
                    end
                end
                LOCK_PEND, LOCKED: begin
                    // Fetch is shut out; the loader owns the port
                    f_gnt_s = 1'b0;
                    l_gnt_s = l_valid;
                end
                default: begin
                    f_gnt_s = 1'b0;
                    l_gnt_s = 1'b0;
                end
            endcase
        end
    end

    // Route the granted request onto the memory port; idle port reads as zero
    always_comb begin
        gnt_req_s = '0;
        if (l_gnt_s) begin
            gnt_req_s = l_req_s;
        end else if (f_gnt_s) begin
            gnt_req_s = f_req_s;
        end else begin
            gnt_req_s = '0;
        end
    end

`ifdef IMEM_ARB_ALIGN_CHECK_EN
    assign bad_align_s = gnt_req_s.valid && addr_misaligned(gnt_req_s.addr[1:0]);
`else
    assign bad_align_s = 1'b0;
`endif

    assign mem_addr   = gnt_req_s.addr[ADDR_BITS-1:0];
    assign mem_we     = l_gnt_s && gnt_req_s.we && !bad_align_s;
    assign mem_wdata  = gnt_req_s.wdata;

    // The loader is "blocked" whenever it asks and someone else gets the port
    assign wait_inc_s = l_valid && !l_gnt_s;

    imem_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (wait_inc_s),
        .clr    (l_gnt_s),
        .at_max (at_max_s)
    );

    // Lock-ownership FSM with a registered locked flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= NORMAL;
            locked_r <= 1'b0;
        end else begin
            case (state_r)
                NORMAL: begin
                    if (l_lock) begin
                        state_r <= LOCK_PEND;
                    end else begin
                        state_r <= NORMAL;
                    end
                    locked_r <= 1'b0;
                end
                LOCK_PEND: begin
                    // Fetch is already denied here, so the only fetch response
                    // still in flight is the one being returned this cycle.
                    if (l_lock) begin
                        state_r  <= LOCKED;
                        locked_r <= 1'b1;
                    end else begin
                        state_r  <= NORMAL;
                        locked_r <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (l_lock) begin
                        state_r  <= LOCKED;
                        locked_r <= 1'b1;
                    end else begin
                        state_r  <= NORMAL;
                        locked_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= NORMAL;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    // Capture read data at the grant edge and present the response next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rvalid_r <= 1'b0;
            l_rvalid_r <= 1'b0;
            err_r      <= 1'b0;
            f_rdata_r  <= 32'h0000_0000;
            l_rdata_r  <= 32'h0000_0000;
        end else begin
            f_rvalid_r <= f_gnt_s;
            l_rvalid_r <= l_gnt_s;
            err_r      <= bad_align_s;
            if (f_gnt_s) begin
                f_rdata_r <= bad_align_s ? 32'h0000_0000 : mem_rdata;
            end else begin
                f_rdata_r <= f_rdata_r;
            end
            if (l_gnt_s) begin
                // Writes answer with zero data so the loader sees a clean ack
                l_rdata_r <= (bad_align_s || l_we) ? 32'h0000_0000 : mem_rdata;
            end else begin
                l_rdata_r <= l_rdata_r;
            end
        end
    end

    assign f_ready  = f_gnt_s;
    assign l_ready  = l_gnt_s;
    assign f_rvalid = f_rvalid_r;
    assign f_rdata  = f_rdata_r;
    assign l_rvalid = l_rvalid_r;
    assign l_rdata  = l_rdata_r;
    assign err      = err_r;
    assign locked   = locked_r;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: self-checking bench for imem_arbiter. A bench-side byte
// memory serves the DUT's memory port; a behavioural model (mode number, wait
// count, reference byte array) predicts grants, port drive and responses.
module tb_imem_arbiter;

    localparam int MAX_WAIT = 4;

`ifdef IMEM_ARB_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        f_valid;
    logic [31:0] f_addr;
    logic        f_ready;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        l_valid;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_lock;
    logic        l_ready;
    logic        l_rvalid;
    logic [31:0] l_rdata;
    logic        locked;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        err;

    imem_arbiter #(.ADDR_BITS(10), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_valid(l_valid), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_ready(l_ready), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .locked(locked),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory: big-endian bytes, combinational read, write on edge
    logic [7:0] emem [0:1023];
    assign mem_rdata = {emem[mem_addr], emem[mem_addr + 10'd1],
                        emem[mem_addr + 10'd2], emem[mem_addr + 10'd3]};
    always @(posedge clk) begin
        if (mem_we) begin
            emem[mem_addr]         = mem_wdata[31:24];
            emem[mem_addr + 10'd1] = mem_wdata[23:16];
            emem[mem_addr + 10'd2] = mem_wdata[15:8];
            emem[mem_addr + 10'd3] = mem_wdata[7:0];
        end
    end

    // Reference model state
    logic [7:0]  rmem [0:1023];
    int          m_mode;        // 0 normal, 1 lock pending, 2 locked
    int          m_wait;
    bit          m_frv, m_lrv, m_err, m_lck;
    logic [31:0] m_frd, m_lrd;
    bit          e_fg, e_lg, e_mis;
    int          e_addr;
    logic [31:0] e_word;
    bit          samp_fr, samp_lr;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_word(input int a);
        return {rmem[a % 1024], rmem[(a + 1) % 1024], rmem[(a + 2) % 1024], rmem[(a + 3) % 1024]};
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_wait = 0;
        m_frv = 0; m_lrv = 0; m_err = 0; m_lck = 0;
        m_frd = 32'h0; m_lrd = 32'h0;
    endtask

    // One clock: predict and check mid-cycle, then advance the model at the edge
    task automatic step();
        logic [31:0] sel;
        @(negedge clk);
        e_fg = 0; e_lg = 0;
        if (m_mode == 0) begin
            if (l_valid && (m_wait >= MAX_WAIT || !f_valid)) e_lg = 1;
            else if (f_valid) e_fg = 1;
        end else begin
            e_lg = l_valid;
        end
        sel    = e_lg ? l_addr : (e_fg ? f_addr : 32'h0);
        e_addr = int'(sel & 32'h3FF);
        e_mis  = ALIGN_EN && (e_fg || e_lg) && (sel[1:0] != 2'b00);
        e_word = ref_word(e_addr);

        chk("f_ready", f_ready, e_fg);
        chk("l_ready", l_ready, e_lg);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", mem_we, e_lg && l_we && !e_mis);
        if (e_lg && l_we && !e_mis) chk("mem_wdata", mem_wdata, l_wdata);
        chk("f_rvalid", f_rvalid, m_frv);
        if (m_frv) chk("f_rdata", f_rdata, m_frd);
        chk("l_rvalid", l_rvalid, m_lrv);
        if (m_lrv) chk("l_rdata", l_rdata, m_lrd);
        chk("err", err, m_err);
        chk("locked", locked, m_lck);
        samp_fr = f_ready;
        samp_lr = l_ready;

        @(posedge clk);
        m_frv = e_fg;
        m_frd = e_mis ? 32'h0 : e_word;
        m_lrv = e_lg;
        m_lrd = (e_mis || l_we) ? 32'h0 : e_word;
        m_err = e_mis;
        if (e_lg && l_we && !e_mis) begin
            rmem[e_addr]              = l_wdata[31:24];
            rmem[(e_addr + 1) % 1024] = l_wdata[23:16];
            rmem[(e_addr + 2) % 1024] = l_wdata[15:8];
            rmem[(e_addr + 3) % 1024] = l_wdata[7:0];
        end
        if (e_lg) m_wait = 0;
        else if (l_valid && m_wait < MAX_WAIT) m_wait++;
        case (m_mode)
            0:       m_mode = l_lock ? 1 : 0;
            default: m_mode = l_lock ? 2 : 0;
        endcase
        m_lck = (m_mode == 2);
        #1;
    endtask

    task automatic idle_inputs();
        f_valid = 0; f_addr = 32'h0;
        l_valid = 0; l_we = 0; l_addr = 32'h0; l_wdata = 32'h0;
    endtask

    initial begin
        logic [31:0] w0, w6;
        rst_n = 0; l_lock = 0;
        idle_inputs();
        for (int i = 0; i < 1024; i++) begin
            emem[i] = 8'($urandom_range(0, 255));
            rmem[i] = emem[i];
        end
        model_reset();

        // Reset state, with requests asserted to show grants are held off
        f_valid = 1; l_valid = 1; l_addr = 32'h44; f_addr = 32'h40;
        #1;
        chk("rst_f_ready", f_ready, 0);
        chk("rst_l_ready", l_ready, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_f_rvalid", f_rvalid, 0);
        chk("rst_l_rvalid", l_rvalid, 0);
        chk("rst_err", err, 0);
        chk("rst_locked", locked, 0);
        chk("rst_f_rdata", f_rdata, 0);
        chk("rst_l_rdata", l_rdata, 0);
        @(negedge clk); rst_n = 1; idle_inputs();
        @(posedge clk); #1;

        // Fetch of word 0 returns the preloaded word one cycle later
        w0 = ref_word(0);
        f_valid = 1; f_addr = 32'h0;
        step();
        chk("fetch0_rvalid", f_rvalid, 1);
        chk("fetch0_rdata", f_rdata, w0);
        idle_inputs(); step();

        // Loader write then fetch of the same word
        l_valid = 1; l_we = 1; l_addr = 32'h8; l_wdata = 32'hDEADBEEF;
        step();
        chk("wr_lrvalid", l_rvalid, 1);
        chk("wr_lrdata", l_rdata, 0);
        idle_inputs(); f_valid = 1; f_addr = 32'h8;
        step();
        chk("rd_after_wr", f_rdata, 32'hDEADBEEF);
        idle_inputs(); step();

        // Lock while fetch is granted: one pending cycle, then 10 locked cycles
        f_valid = 1; f_addr = 32'h20; l_lock = 1;
        step();
        chk("lock_entry_fready", samp_fr, 1);
        step();
        chk("pend_fready", samp_fr, 0);
        chk("locked_set", locked, 1);
        for (int i = 0; i < 10; i++) begin
            l_valid = 1'($urandom_range(0, 1)); l_we = 0; l_addr = rnd_addr();
            step();
            chk("lock_fready", samp_fr, 0);
        end
        l_valid = 0; l_lock = 0;
        step();
        chk("unlock_locked", locked, 0);
        step();
        chk("unlock_fgrant", samp_fr, 1);
        idle_inputs(); step();

        // Reset in the middle of a loader grant
        l_valid = 1; l_we = 0; l_addr = 32'h10;
        @(negedge clk);
        chk("rstmid_pre_lready", l_ready, 1);
        #2 rst_n = 0;
        #1;
        chk("rstmid_l_ready", l_ready, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        chk("rstmid_f_rvalid", f_rvalid, 0);
        chk("rstmid_l_rvalid", l_rvalid, 0);
        chk("rstmid_l_rdata", l_rdata, 0);
        chk("rstmid_f_rdata", f_rdata, 0);
        chk("rstmid_locked", locked, 0);
        @(posedge clk); #1; idle_inputs();
        @(negedge clk); rst_n = 1; model_reset();
        @(posedge clk); #1;
        step();
        chk("rstmid_no_rvalid", l_rvalid, 0);

        // Both requesters continuously busy: 4 fetch grants then 1 loader grant
        for (int i = 0; i < 15; i++) begin
            f_valid = 1; f_addr = 32'h100; l_valid = 1; l_we = 0; l_addr = 32'h200;
            step();
            chk("starve_period", samp_lr, (i % 5) == 4);
        end
        idle_inputs(); step();

        // Misaligned fetch
        w6 = ref_word(6);
        f_valid = 1; f_addr = 32'h6;
        step();
        chk("mis_err", err, ALIGN_EN);
        chk("mis_rdata", f_rdata, ALIGN_EN ? 32'h0 : w6);
        idle_inputs(); step();

        // Randomized traffic with held requests and occasional locking
        samp_fr = 1; samp_lr = 1;
        for (int i = 0; i < 600; i++) begin
            if (!f_valid || samp_fr) begin
                f_valid = ($urandom_range(0, 3) != 0);
                f_addr  = rnd_addr();
            end
            if (!l_valid || samp_lr) begin
                l_valid = ($urandom_range(0, 2) != 0);
                l_we    = 1'($urandom_range(0, 1));
                l_addr  = rnd_addr();
                l_wdata = $urandom;
            end
            if ($urandom_range(0, 19) == 0) l_lock = !l_lock;
            step();
        end
        idle_inputs(); l_lock = 0;
        step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single instruction-memory port between the IF-stage fetch requester and the program-loader/debug requester. Grants at most one word access per cycle. Fetch has priority, bounded by a starvation counter, and the loader can lock the port for bulk program loads. Sits between the IF stage/loader and the byte-addressed, big-endian 1024-byte instruction memory.

## Interface
- `ADDR_BITS`, 10, byte-address bits forwarded to memory (1024 bytes)
- `MAX_WAIT`, 4, consecutive blocked loader cycles before a forced loader grant (1..15)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `f_valid`  in  1  fetch read request
- `f_addr`  in  32  fetch byte address
- `f_ready`  out  1  fetch request accepted this cycle
- `f_rvalid`  out  1  fetch read data valid
- `f_rdata`  out  32  fetch read data
- `l_valid`  in  1  loader request
- `l_we`  in  1  loader write (1) / read (0)
- `l_addr`  in  32  loader byte address
- `l_wdata`  in  32  loader write word, big-endian
- `l_lock`  in  1  loader requests exclusive ownership
- `l_ready`  out  1  loader request accepted
- `l_rvalid`  out  1  loader response valid; also pulses for writes
- `l_rdata`  out  32  loader read data (0 for writes)
- `locked`  out  1  arbiter is in LOCKED state
- `mem_addr`  out  `ADDR_BITS`  memory byte address
- `mem_we`  out  1  memory write strobe
- `mem_wdata`  out  32  memory write word
- `mem_rdata`  in  32  combinational memory read word
- `err`  out  1  misaligned-access response flag (see Configuration)

## Operation
- States: NORMAL, LOCK_PEND, LOCKED.
- NORMAL arbitration:
  - fetch wins unless `wait_cnt == MAX_WAIT`, in which case the loader wins and `wait_cnt` clears.
  - `wait_cnt` increments on each cycle where `l_valid` is high and `l_ready` is low.
  - `wait_cnt` clears on any loader grant. It saturates at `MAX_WAIT`.
- `f_ready`/`l_ready` are combinational grants. Exactly one, or none, is high per cycle.
- The granted request drives `mem_addr = addr[ADDR_BITS-1:0]`, `mem_we`, and `mem_wdata`. Upper address bits are ignored.
- `mem_we` is high only for a granted loader write. It is 0 otherwise, and `mem_addr` is 0 when idle.
- NORMAL -> LOCK_PEND when `l_lock` is sampled high.
- LOCK_PEND:
  - denies fetch;
  - goes to LOCKED once no fetch response is outstanding, i.e. the cycle after the last fetch grant.
- LOCKED:
  - `f_ready = 0`;
  - the loader is granted every cycle it is valid.
- LOCKED -> NORMAL when `l_lock` is sampled low. If `l_lock` drops while in LOCK_PEND, the arbiter goes back to NORMAL.
- Reset mid-operation:
  - all state is cleared immediately and asynchronously;
  - pending responses are dropped (no `rvalid`);
  - a memory write in that cycle is not guaranteed.

## Timing
- Response latency is 1 cycle: `rdata` captures `mem_rdata` at the grant edge, and `rvalid` is high the following cycle for one cycle.
- Responses have no back-pressure. Requesters must accept them.
- Back-to-back grants are allowed, giving one access per cycle of throughput.
- A request is held, with stable fields, until its `ready` is high.
- Reset values:
  - `f_ready`/`l_ready` = 0 while `rst_n` is low;
  - `f_rvalid`, `l_rvalid`, `err`, `locked` = 0;
  - `f_rdata`, `l_rdata` = 0;
  - `mem_we` = 0 and `mem_addr` = 0;
  - state is NORMAL and `wait_cnt` = 0.
- `locked` is registered and is high exactly in the LOCKED state.

## Configuration
- `IMEM_ARB_ALIGN_CHECK_EN` defined:
  - a granted request with `addr[1:0] != 0` gets no memory access (`mem_we = 0`);
  - its response has `rdata = 0` and `err = 1` in the `rvalid` cycle.
- `IMEM_ARB_ALIGN_CHECK_EN` undefined:
  - misaligned addresses pass through unchanged;
  - `err` is tied to 0.

## Structure
- Package `imem_pkg`:
  - `IMEM_BYTES = 1024`;
  - `arb_state_t` enum (NORMAL, LOCK_PEND, LOCKED);
  - `imem_req_t` struct (valid, we, addr, wdata).
- One sub-module, `imem_starve_cnt`: the saturating `wait_cnt` counter with clear and `at_max` output.

## Test plan
- Only `f_valid`, `f_addr = 0x0` -> `f_ready = 1` the same cycle. Next cycle `f_rvalid = 1` and `f_rdata` equals the preloaded word at 0x0. Unchanged otherwise (no memory writes).
- Both valid continuously, `MAX_WAIT = 4` -> fetch is granted 4 cycles, then the loader once, repeating with a period of 5.
- Loader write `l_addr = 0x8`, `l_wdata = 0xDEADBEEF`, then fetch 0x8 -> `f_rdata = 0xDEADBEEF`, and `l_rvalid` pulses with `l_rdata = 0`.
- `l_lock` raised while fetch is granted -> one LOCK_PEND cycle, then `locked = 1` and `f_ready = 0` for 10 cycles. `l_lock` dropped -> fetch is granted the next cycle.
- `rst_n` low in the middle of a loader grant -> all outputs are 0 immediately, no `rvalid` after release, and `wait_cnt` = 0.
- With `IMEM_ARB_ALIGN_CHECK_EN`, fetch at 0x6 -> `mem_we = 0`, then `f_rvalid = 1`, `err = 1`, `f_rdata = 0`.
